// File: rtl/adc_serial_responder.sv
// adc_serial_responder
//
// Responder end of the serial temperature-ADC link. This is a synthesizable model of a
// 10-bit, two-channel serial ADC. It takes the command bits shifted in on din and shifts
// the selected 10-bit code back out on dout. All serial pins are oversampled in the clk
// domain.
//
// Optional feature macro: ADC_RESP_LSBF_EN
//   When defined, a frame with MSBF=0 appends B1..B9 (LSB first) after B0.
//   When undefined, MSBF is ignored and every frame ends after B0.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sclk       serial clock from the initiator (asynchronous)
//   cs_n       chip select, active-low (asynchronous)
//   din        command data from the initiator (asynchronous)
//   ch0_code   channel 0 stand-in code, unsigned
//   ch1_code   channel 1 stand-in code, unsigned
//   dout       serial result bit
//   dout_oe    output enable for dout (1 = driven)
//   conv_done  one-clk pulse in the cycle B0 is driven
//   last_code  code latched for the most recent conversion
//   busy       high in every state except IDLE

module adc_serial_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       din,
    input  logic [9:0] ch0_code,
    input  logic [9:0] ch1_code,
    output logic       dout,
    output logic       dout_oe,
    output logic       conv_done,
    output logic [9:0] last_code,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CMD   = 3'd2,
        NULLB = 3'd3,
        DATA  = 3'd4,
        LSBF  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic       dout_q, dout_d;
    logic       conv_done_q, conv_done_d;
    logic [9:0] last_code_q, last_code_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] cmd_cnt_q, cmd_cnt_d;
    logic       sgl_q, sgl_d;
    logic       odd_q, odd_d;
`ifdef ADC_RESP_LSBF_EN
    logic       msbf_q, msbf_d;
`endif

    logic       sclk_s, cs_s, din_s;
    logic       rise, fall;
    logic [10:0] diff_01, diff_10;
    logic [9:0]  sel_code;

    // Synchronizer shift chains and edge detection on the synchronized sclk.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        din_s       = din_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        rise        = sclk_s & ~sclk_prev_q;
        fall        = ~sclk_s & sclk_prev_q;
    end

    // Code selection. Differential results are computed 11 bits wide so that the top bit
    // flags a negative result, which clamps to zero.
    always_comb begin
        diff_01  = {1'b0, ch0_code} - {1'b0, ch1_code};
        diff_10  = {1'b0, ch1_code} - {1'b0, ch0_code};
        sel_code = 10'd0;
        case ({sgl_q, odd_q})
            2'b10:   sel_code = ch0_code;
            2'b11:   sel_code = ch1_code;
            2'b00:   sel_code = diff_01[10] ? 10'd0 : diff_01[9:0];
            default: sel_code = diff_10[10] ? 10'd0 : diff_10[9:0];
        endcase
    end

    // Frame state machine. A high synchronized cs_n overrides everything, so an sclk edge
    // in the same cycle is discarded.
    always_comb begin
        state_d     = state_q;
        dout_d      = dout_q;
        conv_done_d = 1'b0;
        last_code_d = last_code_q;
        idx_d       = idx_q;
        cmd_cnt_d   = cmd_cnt_q;
        sgl_d       = sgl_q;
        odd_d       = odd_q;
`ifdef ADC_RESP_LSBF_EN
        msbf_d      = msbf_q;
`endif
        if (cs_s) begin
            state_d   = IDLE;
            dout_d    = 1'b0;
            idx_d     = 4'd0;
            cmd_cnt_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    dout_d    = 1'b0;
                    idx_d     = 4'd0;
                    cmd_cnt_d = 2'd0;
                    state_d   = START;
                end
                START: begin
                    dout_d = 1'b0;
                    if (rise && din_s) begin
                        cmd_cnt_d = 2'd0;
                        state_d   = CMD;
                    end
                end
                CMD: begin
                    if (rise) begin
                        case (cmd_cnt_q)
                            2'd0: begin
                                sgl_d     = din_s;
                                cmd_cnt_d = 2'd1;
                            end
                            2'd1: begin
                                odd_d     = din_s;
                                cmd_cnt_d = 2'd2;
                            end
                            default: begin
`ifdef ADC_RESP_LSBF_EN
                                msbf_d = din_s;
`endif
                                last_code_d = sel_code;
                                state_d     = NULLB;
                            end
                        endcase
                    end
                end
                NULLB: begin
                    if (fall) begin
                        dout_d  = 1'b0;
                        idx_d   = 4'd9;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (fall) begin
                        dout_d = last_code_q[idx_q];
                        if (idx_q == 4'd0) begin
                            conv_done_d = 1'b1;
`ifdef ADC_RESP_LSBF_EN
                            if (!msbf_q) begin
                                idx_d   = 4'd1;
                                state_d = LSBF;
                            end else begin
                                state_d = DONE;
                            end
`else
                            state_d = DONE;
`endif
                        end else begin
                            idx_d = idx_q - 4'd1;
                        end
                    end
                end
`ifdef ADC_RESP_LSBF_EN
                LSBF: begin
                    if (fall) begin
                        dout_d = last_code_q[idx_q];
                        if (idx_q == 4'd9) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
`endif
                DONE: begin
                    // The last data bit stays on the pin until the next fall.
                    if (fall) begin
                        dout_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dout_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            dout_q      <= 1'b0;
            conv_done_q <= 1'b0;
            last_code_q <= 10'd0;
            idx_q       <= 4'd0;
            cmd_cnt_q   <= 2'd0;
            sgl_q       <= 1'b0;
            odd_q       <= 1'b0;
`ifdef ADC_RESP_LSBF_EN
            msbf_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            din_sync_q  <= din_sync_d;
            sclk_prev_q <= sclk_prev_d;
            dout_q      <= dout_d;
            conv_done_q <= conv_done_d;
            last_code_q <= last_code_d;
            idx_q       <= idx_d;
            cmd_cnt_q   <= cmd_cnt_d;
            sgl_q       <= sgl_d;
            odd_q       <= odd_d;
`ifdef ADC_RESP_LSBF_EN
            msbf_q      <= msbf_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign dout_oe   = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign conv_done = conv_done_q;
    assign last_code = last_code_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// tb_adc_serial_responder
//
// Directed bench for adc_serial_responder. It uses a table of command/code vectors and
// hand-computed expected results, plus hand-written abort and mid-frame reset sequences.
// Honors ADC_RESP_LSBF_EN in the same way as the design.

module tb_adc_serial_responder;

    localparam int HALF = 8;

    typedef struct {
        logic       sgl;
        logic       odd;
        logic       msbf;
        int         lz;
        logic [9:0] ch0;
        logic [9:0] ch1;
        logic [9:0] code;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       din;
    logic [9:0] ch0_code;
    logic [9:0] ch1_code;
    logic       dout;
    logic       dout_oe;
    logic       conv_done;
    logic [9:0] last_code;
    logic       busy;

    int   total;
    int   bad;
    int   done_cnt;
    logic samp [0:63];
    vec_t vecs [8];

    adc_serial_responder #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .din       (din),
        .ch0_code  (ch0_code),
        .ch1_code  (ch1_code),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .conv_done (conv_done),
        .last_code (last_code),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the clk cycles in which conv_done is high.
    initial done_cnt = 0;
    always @(negedge clk) begin
        if (conv_done) done_cnt <= done_cnt + 1;
    end

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One sclk period: set din, hold the low phase, sample dout, rise, hold high, fall.
    task automatic applyStimulus(input logic d, output logic s);
        din = d;
        waitClks(HALF);
        s = dout;
        sclk = 1'b1;
        waitClks(HALF);
        sclk = 1'b0;
    endtask

    // Select the frame and run n_cycles sclk periods. Leading zeros come first, then the
    // start bit, SGL, ODD and MSBF, then zeros.
    task automatic runFrame(input logic sgl, input logic odd, input logic msbf,
                            input int lz, input int n_cycles);
        logic d;
        logic s;
        cs_n = 1'b0;
        waitClks(4);
        for (int c = 0; c < n_cycles; c++) begin
            if (c < lz)           d = 1'b0;
            else if (c == lz)     d = 1'b1;
            else if (c == lz + 1) d = sgl;
            else if (c == lz + 2) d = odd;
            else if (c == lz + 3) d = msbf;
            else                  d = 1'b0;
            applyStimulus(d, s);
            samp[c] = s;
        end
    endtask

    task automatic checkVector(input vec_t v, input string tag);
        int         lz;
        int         n;
        int         start_cnt;
        logic [9:0] word;
        lz = v.lz;
        ch0_code = v.ch0;
        ch1_code = v.ch1;
        start_cnt = done_cnt;
        n = lz + 16;
`ifdef ADC_RESP_LSBF_EN
        if (!v.msbf) n = lz + 25;
`endif
        runFrame(v.sgl, v.odd, v.msbf, lz, n);
        checkOutput($sformatf("%s/oe_frame", tag), 32'(dout_oe), 32'd1);
        checkOutput($sformatf("%s/busy_frame", tag), 32'(busy), 32'd1);
        checkOutput($sformatf("%s/null", tag), 32'(samp[lz+4]), 32'd0);
        for (int j = 0; j < 10; j++) word[9-j] = samp[lz+5+j];
        checkOutput($sformatf("%s/data", tag), 32'(word), 32'(v.code));
        checkOutput($sformatf("%s/last_code", tag), 32'(last_code), 32'(v.code));
        checkOutput($sformatf("%s/conv_done", tag), 32'(done_cnt - start_cnt), 32'd1);
`ifdef ADC_RESP_LSBF_EN
        if (!v.msbf) begin
            for (int i = 1; i <= 9; i++) begin
                checkOutput($sformatf("%s/lsbf_b%0d", tag, i), 32'(samp[lz+14+i]), 32'(v.code[i]));
            end
            checkOutput($sformatf("%s/done_zero", tag), 32'(samp[lz+24]), 32'd0);
        end else begin
            checkOutput($sformatf("%s/done_zero", tag), 32'(samp[lz+15]), 32'd0);
        end
`else
        checkOutput($sformatf("%s/done_zero", tag), 32'(samp[lz+15]), 32'd0);
`endif
        cs_n = 1'b1;
        waitClks(6);
        checkOutput($sformatf("%s/oe_idle", tag), 32'(dout_oe), 32'd0);
        checkOutput($sformatf("%s/busy_idle", tag), 32'(busy), 32'd0);
        checkOutput($sformatf("%s/dout_idle", tag), 32'(dout), 32'd0);
    endtask

    initial begin
        int   start_cnt;
        logic [2:0] pre;

        total = 0;
        bad   = 0;

        //            sgl   odd   msbf  lz  ch0     ch1     code
        vecs[0] = '{1'b1, 1'b0, 1'b1, 0, 10'h125, 10'h000, 10'h125};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 2, 10'h000, 10'h3FF, 10'h3FF};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 10'h010, 10'h020, 10'h000};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1, 10'h010, 10'h020, 10'h010};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 0, 10'h2C3, 10'h000, 10'h2C3};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 0, 10'h3FF, 10'h001, 10'h3FE};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 0, 10'h155, 10'h2AA, 10'h155};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 3, 10'h200, 10'h200, 10'h000};

        rst_n    = 1'b0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        din      = 1'b0;
        ch0_code = 10'h0;
        ch1_code = 10'h0;
        waitClks(3);
        checkOutput("reset/dout", 32'(dout), 32'd0);
        checkOutput("reset/dout_oe", 32'(dout_oe), 32'd0);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        checkOutput("reset/conv_done", 32'(conv_done), 32'd0);
        checkOutput("reset/last_code", 32'(last_code), 32'd0);
        rst_n = 1'b1;
        waitClks(4);
        checkOutput("post_reset/busy", 32'(busy), 32'd0);

        for (int k = 0; k < 8; k++) begin
            checkVector(vecs[k], $sformatf("vec%0d", k));
        end

        // Abort after B6 (fall 8): the frame must drop without a conv_done pulse.
        $display("[TB] abort sequence");
        ch0_code = 10'h125;
        ch1_code = 10'h000;
        start_cnt = done_cnt;
        runFrame(1'b1, 1'b0, 1'b1, 0, 8);
        waitClks(4);
        pre = {samp[5], samp[6], samp[7]};
        checkOutput("abort/b9_b7", 32'(pre), 32'h2);
        checkOutput("abort/oe_before", 32'(dout_oe), 32'd1);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort/oe_after", 32'(dout_oe), 32'd0);
        checkOutput("abort/busy_after", 32'(busy), 32'd0);
        checkOutput("abort/dout_after", 32'(dout), 32'd0);
        waitClks(20);
        checkOutput("abort/no_conv_done", 32'(done_cnt - start_cnt), 32'd0);
        checkOutput("abort/last_code_kept", 32'(last_code), 32'h125);
        checkVector(vecs[1], "after_abort");

        // Asynchronous reset in the middle of DATA.
        $display("[TB] mid-frame reset sequence");
        ch0_code = 10'h155;
        ch1_code = 10'h2AA;
        runFrame(1'b0, 1'b1, 1'b1, 0, 10);
        waitClks(4);
        checkOutput("midreset/busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset/dout", 32'(dout), 32'd0);
        checkOutput("midreset/dout_oe", 32'(dout_oe), 32'd0);
        checkOutput("midreset/busy", 32'(busy), 32'd0);
        checkOutput("midreset/conv_done", 32'(conv_done), 32'd0);
        checkOutput("midreset/last_code", 32'(last_code), 32'd0);
        waitClks(2);
        cs_n = 1'b1;
        rst_n = 1'b1;
        waitClks(4);
        checkVector(vecs[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
